// File: rtl/channel_readout_pkg.sv
// Shared types and helpers for the channel readout event FIFO.
package channel_readout_pkg;

    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } rd_state_e;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/channel_fifo_mem.sv
// Event storage: DEPTH x DATA_W words plus a per-entry end-of-event flag,
// combinational read, with a separate port that marks an earlier entry as last.
module channel_fifo_mem
    import channel_readout_pkg::*;
#(
    parameter int DEPTH  = 64,
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int PTR_W  = ptr_w(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_last,
    input  logic              flag_set,
    input  logic [PTR_W-1:0]  flag_addr,
    input  logic [PTR_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last
);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  flag_reg;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_addr] <= wr_data;
        end
    end

    // Flag set targets the previous entry, so it never collides with a write.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_flag
            always_ff @(posedge clk) begin
                if (wr_en && (wr_addr == PTR_W'(gi))) begin
                    flag_reg[gi] <= wr_last;
                end else if (flag_set && (flag_addr == PTR_W'(gi))) begin
                    flag_reg[gi] <= 1'b1;
                end
            end
        end
    endgenerate

    assign rd_data = data_mem[rd_addr];
    assign rd_last = flag_reg[rd_addr];

endmodule

// File: rtl/channel_readout_fifo.sv
// Event FIFO behind the channel digital top: groups write bursts into events.
// Optional drop counter enabled by defining CHANNEL_FIFO_DROP_COUNT_EN.
module channel_readout_fifo
    import channel_readout_pkg::*;
#(
    parameter int DEPTH     = 64,
    parameter int DATA_W    = DATA_W_DEFAULT,
    parameter int EVT_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_Write,
    input  logic [DATA_W-1:0]    i_Data,
    output logic                 o_HalfFull,
    output logic                 o_Full,
    output logic [DATA_W-1:0]    o_Data,
    output logic                 o_Last,
    output logic                 o_Valid,
    input  logic                 i_Ready,
    output logic [EVT_CNT_W-1:0] o_EventCount,
    output logic                 o_Overflow,
    input  logic                 i_ClearOverflow,
    output logic [15:0]          o_DropCount
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [0:0] ST_IDLE   = IDLE;
    localparam logic [0:0] ST_STREAM = STREAM;
    localparam logic [EVT_CNT_W-1:0] EVT_MAX = {EVT_CNT_W{1'b1}};

    logic [PTR_W-1:0]     wr_ptr_reg;
    logic [PTR_W-1:0]     rd_ptr_reg;
    logic [CNT_W-1:0]     count_reg;
    logic                 hold_valid_reg;
    logic [DATA_W-1:0]    hold_data_reg;
    logic                 evt_open_reg;
    logic [EVT_CNT_W-1:0] evt_count_reg;
    logic                 overflow_reg;
    logic [0:0]           state_reg;
    logic [0:0]           state_next;

    logic              full;
    logic              push;
    logic              push_last;
    logic              store;
    logic              drop;
    logic              trunc;
    logic              streaming;
    logic              pop;
    logic              evt_inc;
    logic              evt_dec;
    logic [PTR_W-1:0]  prev_addr;
    logic [DATA_W-1:0] rd_data_raw;
    logic              rd_last_raw;

    // The held word is the event's last one when the write strobe has gone low.
    assign full      = (count_reg == CNT_W'(DEPTH));
    assign push      = hold_valid_reg;
    assign push_last = ~i_Write;
    assign store     = push & ~full;
    assign drop      = push & full;
    assign trunc     = drop & push_last & evt_open_reg;
    assign streaming = (state_reg == ST_STREAM);
    assign pop       = streaming & i_Ready;
    assign evt_inc   = (store & push_last) | trunc;
    assign evt_dec   = pop & rd_last_raw;
    assign prev_addr = wr_ptr_reg - PTR_W'(1);

    channel_fifo_mem #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .PTR_W  (PTR_W)
    ) u_mem (
        .clk       (clk),
        .wr_en     (store),
        .wr_addr   (wr_ptr_reg),
        .wr_data   (hold_data_reg),
        .wr_last   (push_last),
        .flag_set  (trunc),
        .flag_addr (prev_addr),
        .rd_addr   (rd_ptr_reg),
        .rd_data   (rd_data_raw),
        .rd_last   (rd_last_raw)
    );

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (evt_count_reg != '0) state_next = ST_STREAM;
            ST_STREAM: if (evt_dec) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= '0;
            evt_open_reg   <= 1'b0;
            evt_count_reg  <= '0;
            overflow_reg   <= 1'b0;
            state_reg      <= ST_IDLE;
        end else begin
            hold_valid_reg <= i_Write;
            if (i_Write) begin
                hold_data_reg <= i_Data;
            end
            if (store) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg <= count_reg + CNT_W'(store) - CNT_W'(pop);
            // Remembers whether any word of the in-flight event reached memory.
            if (push) begin
                evt_open_reg <= push_last ? 1'b0 : (evt_open_reg | store);
            end
            if (evt_inc && !evt_dec && (evt_count_reg != EVT_MAX)) begin
                evt_count_reg <= evt_count_reg + EVT_CNT_W'(1);
            end else if (evt_dec && !evt_inc && (evt_count_reg != '0)) begin
                evt_count_reg <= evt_count_reg - EVT_CNT_W'(1);
            end
            if (drop) begin
                overflow_reg <= 1'b1;
            end else if (i_ClearOverflow) begin
                overflow_reg <= 1'b0;
            end
            state_reg <= state_next;
        end
    end

`ifdef CHANNEL_FIFO_DROP_COUNT_EN
    logic [15:0] drop_count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            drop_count_reg <= '0;
        end else if (i_ClearOverflow) begin
            drop_count_reg <= drop ? 16'd1 : 16'd0;
        end else if (drop && (drop_count_reg != 16'hFFFF)) begin
            drop_count_reg <= drop_count_reg + 16'd1;
        end
    end

    assign o_DropCount = drop_count_reg;
`else
    assign o_DropCount = '0;
`endif

    assign o_HalfFull   = (count_reg >= CNT_W'(DEPTH / 2));
    assign o_Full       = full;
    assign o_Valid      = streaming;
    assign o_Data       = streaming ? rd_data_raw : '0;
    assign o_Last       = streaming & rd_last_raw;
    assign o_EventCount = evt_count_reg;
    assign o_Overflow   = overflow_reg;

endmodule

// File: tb/tb_channel_readout_fifo.sv
// Directed bench for channel_readout_fifo: a cycle-exact vector table for one
// short event, then hand-written burst/overflow/pileup/reset sequences.
module tb_channel_readout_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr;
    logic [15:0] data;
    logic        ready;
    logic        clr;
    logic        o_HalfFull;
    logic        o_Full;
    logic [15:0] o_Data;
    logic        o_Last;
    logic        o_Valid;
    logic [7:0]  o_EventCount;
    logic        o_Overflow;
    logic [15:0] o_DropCount;

    int checks = 0;
    int errors = 0;

`ifdef CHANNEL_FIFO_DROP_COUNT_EN
    localparam bit DC_EN = 1'b1;
`else
    localparam bit DC_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    channel_readout_fifo #(.DEPTH(64), .DATA_W(16), .EVT_CNT_W(8)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_Write         (wr),
        .i_Data          (data),
        .o_HalfFull      (o_HalfFull),
        .o_Full          (o_Full),
        .o_Data          (o_Data),
        .o_Last          (o_Last),
        .o_Valid         (o_Valid),
        .i_Ready         (ready),
        .o_EventCount    (o_EventCount),
        .o_Overflow      (o_Overflow),
        .i_ClearOverflow (clr),
        .o_DropCount     (o_DropCount)
    );

    typedef struct {
        logic        wr;
        logic [15:0] data;
        logic        ready;
        logic        exp_valid;
        logic        exp_last;
        logic [15:0] exp_data;
        logic [7:0]  exp_evt;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic burst(input logic [15:0] base, input int len);
        for (int i = 0; i < len; i++) begin
            wr   = 1'b1;
            data = base + 16'(i);
            tick();
        end
        wr = 1'b0;
        $display("burst base=%h len=%0d written", base, len);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic read_event(input logic [15:0] base, input int len);
        int n = 0;
        ready = 1'b1;
        while (!o_Valid && n < 64) begin
            tick();
            n++;
        end
        check("event_valid_wait", o_Valid, 1);
        for (int k = 0; k < len; k++) begin
            check($sformatf("ev%h_w%0d_valid", base, k), o_Valid, 1);
            check($sformatf("ev%h_w%0d_data", base, k), o_Data, base + 16'(k));
            check($sformatf("ev%h_w%0d_last", base, k), o_Last, (k == len - 1));
            tick();
        end
        ready = 1'b0;
        $display("event base=%h len=%0d read", base, len);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // 3-word event, ready high: data out three cycles after the last write.
        vecs[0] = '{1'b1, 16'h00A0, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0};
        vecs[1] = '{1'b1, 16'h00A1, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0};
        vecs[2] = '{1'b1, 16'h00A2, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd1};
        vecs[4] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h00A0, 8'd1};
        vecs[5] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h00A1, 8'd1};
        vecs[6] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h00A2, 8'd1};
        vecs[7] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0};
        vecs[8] = '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 16'h0000, 8'd0};

        reset = 1'b1; wr = 1'b0; data = '0; ready = 1'b0; clr = 1'b0;
        idle(2);
        reset = 1'b0;
        check("rst_valid", o_Valid, 0);
        check("rst_last", o_Last, 0);
        check("rst_data", o_Data, 0);
        check("rst_halffull", o_HalfFull, 0);
        check("rst_full", o_Full, 0);
        check("rst_evt", o_EventCount, 0);
        check("rst_ovf", o_Overflow, 0);
        check("rst_dropcnt", o_DropCount, 0);

        for (int i = 0; i < 9; i++) begin
            wr    = vecs[i].wr;
            data  = vecs[i].data;
            ready = vecs[i].ready;
            tick();
            check($sformatf("vec%0d_valid", i), o_Valid, vecs[i].exp_valid);
            check($sformatf("vec%0d_last", i), o_Last, vecs[i].exp_last);
            check($sformatf("vec%0d_data", i), o_Data, vecs[i].exp_data);
            check($sformatf("vec%0d_evt", i), o_EventCount, vecs[i].exp_evt);
            $display("vec %0d wr=%b data=%h valid=%b last=%b out=%h evt=%0d",
                     i, wr, data, o_Valid, o_Last, o_Data, o_EventCount);
        end
        wr = 1'b0; ready = 1'b0;

        // 1: single 16-word burst with ready high
        ready = 1'b1;
        burst(16'h0100, 16);
        idle(1);
        check("t1_evt_after2", o_EventCount, 1);
        read_event(16'h0100, 16);
        check("t1_evt_end", o_EventCount, 0);

        // 2: two bursts held back, then drained
        burst(16'h0200, 16);
        idle(4);
        burst(16'h0300, 16);
        idle(3);
        check("t2_halffull", o_HalfFull, 1);
        check("t2_full", o_Full, 0);
        check("t2_evt", o_EventCount, 2);
        check("t2_hold_valid", o_Valid, 1);
        check("t2_hold_data0", o_Data, 16'h0200);
        tick();
        check("t2_hold_data1", o_Data, 16'h0200);
        read_event(16'h0200, 16);
        check("t2_halffull_drop", o_HalfFull, 0);
        read_event(16'h0300, 16);
        check("t2_evt_end", o_EventCount, 0);

        // 3: overflow truncates the fourth event
        burst(16'h1000, 20); idle(2);
        burst(16'h2000, 20); idle(2);
        burst(16'h3000, 20); idle(2);
        burst(16'h4000, 20); idle(3);
        check("t3_full", o_Full, 1);
        check("t3_ovf", o_Overflow, 1);
        check("t3_evt", o_EventCount, 4);
        check("t3_dropcnt", o_DropCount, DC_EN ? 16 : 0);

        // 4: burst into a full FIFO, then clear with and without a same-cycle drop
        burst(16'h5000, 16); idle(3);
        check("t4_evt", o_EventCount, 4);
        check("t4_dropcnt", o_DropCount, DC_EN ? 32 : 0);
        wr = 1'b1; data = 16'h5555; tick();
        wr = 1'b0; clr = 1'b1; tick();
        clr = 1'b0;
        check("t4_clr_drop_ovf", o_Overflow, 1);
        check("t4_clr_drop_cnt", o_DropCount, DC_EN ? 1 : 0);
        check("t4_clr_drop_evt", o_EventCount, 4);
        clr = 1'b1; tick(); clr = 1'b0;
        check("t4_clr_ovf", o_Overflow, 0);
        check("t4_clr_cnt", o_DropCount, 0);
        read_event(16'h1000, 20);
        read_event(16'h2000, 20);
        read_event(16'h3000, 20);
        read_event(16'h4000, 4);
        check("t4_evt_end", o_EventCount, 0);
        check("t4_full_end", o_Full, 0);
        check("t4_hf_end", o_HalfFull, 0);

        // 5: 32-cycle pileup forms one event
        burst(16'h8000, 32); idle(3);
        check("t5_evt", o_EventCount, 1);
        check("t5_halffull", o_HalfFull, 1);
        read_event(16'h8000, 32);
        check("t5_evt_end", o_EventCount, 0);

        // 6: reset in the middle of a readout
        burst(16'h6000, 16); idle(2);
        burst(16'h6100, 20); idle(3);
        check("t6_halffull_pre", o_HalfFull, 1);
        ready = 1'b1;
        begin
            int n = 0;
            while (!o_Valid && n < 64) begin tick(); n++; end
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("t6_w%0d", k), o_Data, 16'h6000 + 16'(k));
            tick();
        end
        check("t6_w4", o_Data, 16'h6004);
        reset = 1'b1; tick(); reset = 1'b0; ready = 1'b0;
        check("t6_rst_valid", o_Valid, 0);
        check("t6_rst_evt", o_EventCount, 0);
        check("t6_rst_hf", o_HalfFull, 0);
        check("t6_rst_data", o_Data, 0);
        burst(16'h7000, 8); idle(1);
        read_event(16'h7000, 8);
        check("t6_evt_end", o_EventCount, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/channel_readout_fifo.md
Name: channel_readout_fifo

Overview:
Event buffer directly downstream of ChannelDigitalTop. It captures the channel's 16-bit write stream (address word plus sample words) and groups each contiguous write burst into one event. It stores events in a circular buffer and returns the half-full back-pressure flag the channel uses to gate triggering. A valid/ready read port delivers complete events, marked with an end-of-event flag, to the readout arbiter.

Parameters:
DEPTH, 64, number of 16-bit entries; power of two, >= 4
DATA_W, 16, word width; matches the channel write word
EVT_CNT_W, 8, width of the complete-event counter; saturates, never wraps

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
i_Write  in  1  channel write strobe; one word per high cycle
i_Data  in  DATA_W  channel write word
o_HalfFull  out  1  stored count >= DEPTH/2; feeds channel s_FifoHalfFull
o_Full  out  1  stored count == DEPTH
o_Data  out  DATA_W  read word
o_Last  out  1  o_Data is the final word of its event
o_Valid  out  1  o_Data/o_Last valid
i_Ready  in  1  consumer accepts the word when o_Valid & i_Ready
o_EventCount  out  EVT_CNT_W  complete events stored and not yet fully read
o_Overflow  out  1  sticky: at least one word dropped
i_ClearOverflow  in  1  clears o_Overflow; a same-cycle drop wins
o_DropCount  out  16  dropped-word count (see Optional Feature)

Behaviour:
- Reset: pointers and count = 0; o_Valid=0, o_Last=0, o_Data=0, o_HalfFull=0, o_Full=0, o_EventCount=0, o_Overflow=0, hold stage empty, FSM=IDLE. Reset mid-event or mid-read discards everything; the partial event is lost.
- Input hold stage (1-cycle latency): on a cycle with i_Write=1 and the hold stage full, push the held word with last=0, then load i_Data. On a cycle with i_Write=0 and the hold stage full, push the held word with last=1 and empty the stage. A burst is maximal contiguous i_Write=1; back-to-back pileup writes form one event.
- Push when count==DEPTH (full sampled at start of cycle, before any same-cycle pop): word dropped, o_Overflow<=1.
  - If the dropped word has last=1 and the current event already stored >=1 word: set the last flag of the entry at wr_ptr-1 (truncated event) and increment the event count.
  - If no word of the event was stored: no increment.
- Event count: +1 on a stored last push (or truncation mark); -1 on a handshake with o_Last=1. Both in the same cycle leave it unchanged. Saturates at max.
- o_HalfFull and o_Full are derived from the count register and reflect a push or pop one cycle after it.
- Read FSM:
  - IDLE: o_Valid=0. Move to STREAM next cycle when o_EventCount != 0.
  - STREAM: o_Valid=1. o_Data = mem[rd_ptr] and o_Last = flag[rd_ptr], read combinationally.
  - On o_Valid & i_Ready: rd_ptr+1. If o_Last=1, return to IDLE.
  - o_Data is held stable while o_Valid & !i_Ready.
- Latency: last word of a burst written (cycle N) -> pushed at N+1 -> o_EventCount increments at N+2 -> o_Valid at N+3.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is log2(DEPTH)+1 bits.

Optional Feature:
CHANNEL_FIFO_DROP_COUNT_EN
- Defined: o_DropCount increments on every dropped word, saturates at 0xFFFF, and clears on reset or i_ClearOverflow (a same-cycle drop yields 1).
- Undefined: o_DropCount is tied to 0 and no counter logic exists.

Decomposition:
- Package channel_readout_pkg: DATA_W default, read-FSM state enum {IDLE, STREAM}, helper function for pointer width.
- Sub-module channel_fifo_mem: DEPTH x DATA_W storage plus a DEPTH x 1 last-flag array, with a write port and an independent flag-set port at wr_ptr-1.

Test Plan:
1. One 16-cycle burst 0x0100..0x010F, i_Ready=1 -> o_EventCount=1 two cycles after the last write; 16 words out in order; o_Last only on 0x010F; o_EventCount back to 0.
2. i_Ready=0, two 16-word bursts with a 4-cycle gap -> count 32, o_HalfFull=1, o_EventCount=2. Raise i_Ready -> 32 words with o_Last on words 16 and 32; o_HalfFull drops once the count falls below 32.
3. i_Ready=0, three 20-word bursts, then a fourth 20-word burst -> 64 stored, 16 dropped, o_Overflow=1, o_EventCount=4; the fourth event reads out as 4 words with o_Last on the 4th; o_DropCount=16 (feature enabled).
4. FIFO full, a further 16-word burst -> all dropped, o_EventCount unchanged at 4, o_DropCount=32; i_ClearOverflow -> o_Overflow=0, o_DropCount=0.
5. Pileup: i_Write high for 32 continuous cycles -> a single event of 32 words, one o_Last.
6. reset asserted mid-readout (word 5 of 16) -> next cycle o_Valid=0, o_EventCount=0, o_HalfFull=0; a fresh burst afterwards reads out correctly.
